// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: the md_op encoding and
// small helpers. The controller and hazard unit import this package too.
package md_unit_pkg;

   localparam int MD_OP_W = 3;

   typedef enum logic [MD_OP_W-1:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   // True for the ops that occupy the unit for a multi-cycle busy period.
   function automatic logic is_md_arith(input logic [MD_OP_W-1:0] op);
      return (op <= 3'd3);
   endfunction

   // Used to size the countdown register from the two latency parameters.
   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational datapath: product or quotient/remainder packed as {hi_n, lo_n}.
// A zero divisor returns the current {hi, lo} so the architectural registers
// are left unchanged when the busy period completes.
module md_calc
   import md_unit_pkg::*;
(
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   input  logic [31:0]        hi,
   input  logic [31:0]        lo,
   input  logic [MD_OP_W-1:0] md_op,
   output logic [63:0]        result
);

   logic [63:0] a_sx, b_sx, a_zx, b_zx;
   logic [63:0] prod_signed, prod_unsigned;
   logic        a_neg, b_neg, b_zero;
   logic [31:0] b_safe, a_mag, b_mag, b_mag_safe;
   logic [31:0] uq, ur, mq, mr, sq, sr;

   assign a_sx = {{32{a[31]}}, a};
   assign b_sx = {{32{b[31]}}, b};
   assign a_zx = {32'd0, a};
   assign b_zx = {32'd0, b};

   // The low 64 bits of a product of sign-extended operands equal the signed product.
   assign prod_signed   = a_sx * b_sx;
   assign prod_unsigned = a_zx * b_zx;

   assign b_zero = (b == 32'd0);
   assign b_safe = b_zero ? 32'd1 : b;

   assign uq = a / b_safe;
   assign ur = a % b_safe;

   // Signed divide on magnitudes; |0x80000000| is representable as unsigned,
   // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
   assign a_neg      = a[31];
   assign b_neg      = b[31];
   assign a_mag      = a_neg ? (~a + 32'd1) : a;
   assign b_mag      = b_neg ? (~b + 32'd1) : b;
   assign b_mag_safe = b_zero ? 32'd1 : b_mag;
   assign mq         = a_mag / b_mag_safe;
   assign mr         = a_mag % b_mag_safe;
   assign sq         = (a_neg ^ b_neg) ? (~mq + 32'd1) : mq;
   assign sr         = a_neg ? (~mr + 32'd1) : mr;

   // Select the result for the requested op, holding {hi, lo} on divide-by-zero.
   always_comb begin
      result = {hi, lo};
      case (md_op)
         MD_MULT:  result = prod_signed;
         MD_MULTU: result = prod_unsigned;
         MD_DIV: begin
            if (b_zero) result = {hi, lo};
            else        result = {sr, sq};
         end
         MD_DIVU: begin
            if (b_zero) result = {hi, lo};
            else        result = {ur, uq};
         end
         default:  result = {hi, lo};
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit. Owns HI/LO, latches the pending result at
// accept and commits it on the last edge of a fixed-length busy countdown.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   output logic               busy,
   output logic [31:0]        hi,
   output logic [31:0]        lo
);

   localparam int CNT_MAX = max_int(MULT_CYCLES, DIV_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi_n, lo_n;
   logic [63:0]      calc_res;
   logic             idle;

   md_calc u_calc (
      .a      (a),
      .b      (b),
      .hi     (hi),
      .lo     (lo),
      .md_op  (md_op),
      .result (calc_res)
   );

   assign idle = (cnt == CNT_ZERO);
   // busy depends only on the countdown register, never on start.
   assign busy = ~idle;

   // Accept new ops when idle, otherwise count down and commit on the final edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= CNT_ZERO;
         hi   <= 32'd0;
         lo   <= 32'd0;
         hi_n <= 32'd0;
         lo_n <= 32'd0;
      end else if (!idle) begin
         cnt <= cnt - CNT_ONE;
         if (cnt == CNT_ONE) begin
            hi <= hi_n;
            lo <= lo_n;
         end
      end else if (start) begin
         case (md_op)
            MD_MULT, MD_MULTU: begin
               hi_n <= calc_res[63:32];
               lo_n <= calc_res[31:0];
               cnt  <= MULT_LOAD;
            end
            MD_DIV, MD_DIVU: begin
               hi_n <= calc_res[63:32];
               lo_n <= calc_res[31:0];
               cnt  <= DIV_LOAD;
            end
            MD_MTHI: hi <= a;
            MD_MTLO: lo <= a;
            default: ;
         endcase
      end
   end

endmodule
